mem_sync_engine: RTL and testbench

- Parametrised successor to the split instruction/data memory.
- Two inferred single-port RAMs: IM and DM. CPU writes go to DM only; a dirty-address log records every written word.
- A sync FSM copies logged DM words into IM on fence.i or when the log fills, with a handshake and a completion pulse.
- Adds over the previous generation: a correct FIFO log with a count, dedup of back-to-back same-address writes, one-entry-per-cycle pipelined drain, and explicit read-valid strobes.

---
 rtl/mem_sync_pkg.sv | 19 +
 rtl/mem_sync_engine_sp_ram.sv | 40 ++++
 rtl/mem_sync_engine.sv | 140 ++++++++++++++
 tb/tb_mem_sync_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Shared types and defaults for the IM/DM synchronisation engine.
package mem_sync_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LOG_AW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_sync_engine_sp_ram.sv
// Single-port RAM: 1-cycle synchronous read, per-byte write, read returns old data.
module sp_ram
  import mem_sync_pkg::*;
#(
  parameter int AW = DEF_ADDR_W,
  parameter int DW = DEF_DATA_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ren,
  input  logic            i_wen,
  input  logic [DW/8-1:0] i_ben,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata
);

  localparam int NB = byte_lanes(DW);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register resets.
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      for (int b = 0; b < NB; b++) begin
        if (i_ben[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: non-blocking assignment here is what makes a same-cycle read see the old word.
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_rdata <= '0;
    else if (i_ren) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_sync_engine.sv
// Split IM/DM memory with a dirty-address log and a pipelined DM->IM sync FSM.
module mem_sync_engine
  import mem_sync_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG_AW = DEF_LOG_AW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_im_ren,
  input  logic [ADDR_W-1:0]   i_im_addr,
  output logic [DATA_W-1:0]   o_im_rdata,
  output logic                o_im_rvalid,
  input  logic                i_dm_ren,
  input  logic                i_dm_wen,
  input  logic [DATA_W/8-1:0] i_dm_ben,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_dm_rvalid,
  input  logic                i_fence_i,
  output logic                o_ready,
  output logic                o_sync_done,
  output logic [LOG_AW:0]     o_log_count
);

  localparam int              NB       = byte_lanes(DATA_W);
  localparam logic [LOG_AW:0] LOG_FULL = (LOG_AW+1)'(2**LOG_AW);
  localparam logic [LOG_AW:0] LOG_ONE  = (LOG_AW+1)'(1);

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_log [2**LOG_AW];
  logic [LOG_AW-1:0]   r_head, r_tail;
  logic [LOG_AW:0]     r_count, w_count_next;
  logic [ADDR_W-1:0]   r_last_addr;
  logic                r_im_wr_pend;
  logic [ADDR_W-1:0]   r_im_wr_addr;
  logic                r_im_rvalid, r_dm_rvalid;

  logic                w_ready, w_wr_acc, w_fence_acc, w_append, w_pop;
  logic [ADDR_W-1:0]   w_pop_addr;
  logic                w_dm_ren, w_im_ren;
  logic [ADDR_W-1:0]   w_dm_addr, w_im_addr;
  logic [DATA_W-1:0]   w_dm_rdata, w_im_rdata;

  assign w_ready     = (r_state == ST_IDLE) && (r_count != LOG_FULL);
  assign w_wr_acc    = w_ready && i_dm_wen;
  assign w_fence_acc = w_ready && i_fence_i;
  // Back-to-back writes to one word need a single log entry.
  assign w_append    = w_wr_acc && !((r_count != '0) && (i_dm_addr == r_last_addr));
  assign w_pop       = (r_state == ST_DRAIN);
  assign w_pop_addr  = r_log[r_head];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_count_next = r_count;
    w_state_next = r_state;
    if (w_append)   w_count_next = r_count + LOG_ONE;
    else if (w_pop) w_count_next = r_count - LOG_ONE;

    unique case (r_state)
      ST_IDLE: begin
        if (w_fence_acc)                  w_state_next = (w_count_next != '0) ? ST_DRAIN : ST_DONE;
        else if (w_count_next == LOG_FULL) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: if (r_count == LOG_ONE) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_last_addr  <= '0;
      r_im_wr_pend <= 1'b0;
      r_im_wr_addr <= '0;
      r_im_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_im_wr_pend <= w_pop;
      r_im_wr_addr <= w_pop_addr;
      r_im_rvalid  <= w_ready && i_im_ren;
      r_dm_rvalid  <= w_ready && i_dm_ren;
      if (w_append) begin
        r_tail      <= r_tail + 1'b1;
        r_last_addr <= i_dm_addr;
      end
      if (w_pop) r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_append) r_log[r_tail] <= i_dm_addr;
  end

  // While draining the FSM owns the DM port; the IM write lands one cycle after each pop.
  assign w_dm_ren  = w_pop || (w_ready && i_dm_ren);
  assign w_dm_addr = w_pop ? w_pop_addr : i_dm_addr;
  assign w_im_ren  = w_ready && i_im_ren;
  assign w_im_addr = r_im_wr_pend ? r_im_wr_addr : i_im_addr;

  sp_ram #(.AW(ADDR_W), .DW(DATA_W)) u_dm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ren   (w_dm_ren),
    .i_wen   (w_wr_acc),
    .i_ben   (i_dm_ben),
    .i_addr  (w_dm_addr),
    .i_wdata (i_dm_wdata),
    .o_rdata (w_dm_rdata)
  );

  sp_ram #(.AW(ADDR_W), .DW(DATA_W)) u_im (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ren   (w_im_ren),
    .i_wen   (r_im_wr_pend),
    .i_ben   ({NB{1'b1}}),
    .i_addr  (w_im_addr),
    .i_wdata (w_dm_rdata),
    .o_rdata (w_im_rdata)
  );

  assign o_im_rdata  = w_im_rdata;
  assign o_im_rvalid = r_im_rvalid;
  assign o_dm_rdata  = w_dm_rdata;
  assign o_dm_rvalid = r_dm_rvalid;
  assign o_ready     = w_ready;
  assign o_sync_done = (r_state == ST_DONE);
  assign o_log_count = r_count;

endmodule

// File: tb/tb_mem_sync_engine.sv
// Directed, table-driven bench for mem_sync_engine (default parameters).
module tb_mem_sync_engine;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LA = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_im_ren;
  logic [AW-1:0] i_im_addr;
  logic [DW-1:0] o_im_rdata;
  logic          o_im_rvalid;
  logic          i_dm_ren;
  logic          i_dm_wen;
  logic [3:0]    i_dm_ben;
  logic [AW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic [DW-1:0] o_dm_rdata;
  logic          o_dm_rvalid;
  logic          i_fence_i;
  logic          o_ready;
  logic          o_sync_done;
  logic [LA:0]   o_log_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum logic {OP_WR, OP_RD} op_e;
  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    ben;
    logic [DW-1:0] exp_rdata;
    logic [LA:0]   exp_count;
  } vec_t;

  vec_t vecs [13];

  mem_sync_engine #(.ADDR_W(AW), .DATA_W(DW), .LOG_AW(LA)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_im_ren    (i_im_ren),
    .i_im_addr   (i_im_addr),
    .o_im_rdata  (o_im_rdata),
    .o_im_rvalid (o_im_rvalid),
    .i_dm_ren    (i_dm_ren),
    .i_dm_wen    (i_dm_wen),
    .i_dm_ben    (i_dm_ben),
    .i_dm_addr   (i_dm_addr),
    .i_dm_wdata  (i_dm_wdata),
    .o_dm_rdata  (o_dm_rdata),
    .o_dm_rvalid (o_dm_rvalid),
    .i_fence_i   (i_fence_i),
    .o_ready     (o_ready),
    .o_sync_done (o_sync_done),
    .o_log_count (o_log_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_im_ren = 1'b0; i_im_addr = '0;
    i_dm_ren = 1'b0; i_dm_wen = 1'b0; i_dm_ben = 4'h0;
    i_dm_addr = '0; i_dm_wdata = '0; i_fence_i = 1'b0;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    i_dm_addr  = v.addr;
    i_dm_wdata = v.data;
    i_dm_ben   = v.ben;
    i_dm_wen   = (v.op == OP_WR);
    i_dm_ren   = (v.op == OP_RD);
    step();
    idle_inputs();
    check($sformatf("vec%0d count", idx), 64'(o_log_count), 64'(v.exp_count));
    check($sformatf("vec%0d dm_rvalid", idx), 64'(o_dm_rvalid), 64'(v.op == OP_RD));
    if (v.op == OP_RD)
      check($sformatf("vec%0d dm_rdata", idx), 64'(o_dm_rdata), 64'(v.exp_rdata));
  endtask

  task automatic im_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
    i_im_ren = 1'b1; i_im_addr = addr;
    step();
    idle_inputs();
    check({tag, " im_rvalid"}, 64'(o_im_rvalid), 64'd1);
    check({tag, " im_rdata"}, 64'(o_im_rdata), 64'(exp));
  endtask

  // Fence at cycle 0 (optionally with a same-cycle write); n = entries synced.
  task automatic run_sync(input int n, input string tag, input bit wr = 1'b0,
                          input logic [AW-1:0] wa = '0, input logic [DW-1:0] wd = '0);
    int dc;
    dc = (n == 0) ? 1 : n + 2;
    i_fence_i = 1'b1;
    if (wr) begin
      i_dm_wen = 1'b1; i_dm_ben = 4'hF; i_dm_addr = wa; i_dm_wdata = wd;
    end
    step();
    idle_inputs();
    i_im_ren = 1'b1; i_im_addr = 14'd3;
    for (int c = 1; c <= dc + 1; c++) begin
      if (c == dc) i_im_ren = 1'b0;
      check($sformatf("%s c%0d sync_done", tag, c), 64'(o_sync_done), 64'(c == dc));
      check($sformatf("%s c%0d ready", tag, c), 64'(o_ready), 64'(c == dc + 1));
      check($sformatf("%s c%0d im_rvalid", tag, c), 64'(o_im_rvalid), 64'd0);
      if (c <= n)
        check($sformatf("%s c%0d count", tag, c), 64'(o_log_count), 64'(n - c + 1));
      if (c == dc + 1)
        check($sformatf("%s end count", tag), 64'(o_log_count), 64'd0);
      if (c <= dc) step();
    end
  endtask

  initial begin
    int  waited;
    bit  seen;

    vecs[0]  = '{OP_WR, 14'd5,  32'hDEADBEEF, 4'hF, 32'h0,        9'd1};
    vecs[1]  = '{OP_RD, 14'd5,  32'h0,        4'h0, 32'hDEADBEEF, 9'd1};
    vecs[2]  = '{OP_WR, 14'd3,  32'h000000A0, 4'hF, 32'h0,        9'd1};
    vecs[3]  = '{OP_WR, 14'd3,  32'h000000A3, 4'hF, 32'h0,        9'd1};
    vecs[4]  = '{OP_WR, 14'd7,  32'h00000077, 4'hF, 32'h0,        9'd2};
    vecs[5]  = '{OP_RD, 14'd3,  32'h0,        4'h0, 32'h000000A3, 9'd2};
    vecs[6]  = '{OP_WR, 14'd9,  32'h11223344, 4'hF, 32'h0,        9'd1};
    vecs[7]  = '{OP_WR, 14'd9,  32'hAABBCCDD, 4'h5, 32'h0,        9'd1};
    vecs[8]  = '{OP_RD, 14'd9,  32'h0,        4'h0, 32'h11BB33DD, 9'd1};
    vecs[9]  = '{OP_WR, 14'd5,  32'h5555AAAA, 4'hF, 32'h0,        9'd2};
    vecs[10] = '{OP_WR, 14'd20, 32'h20202020, 4'hF, 32'h0,        9'd1};
    vecs[11] = '{OP_WR, 14'd21, 32'h21212121, 4'hF, 32'h0,        9'd2};
    vecs[12] = '{OP_WR, 14'd20, 32'h2020ABCD, 4'hF, 32'h0,        9'd3};

    idle_inputs();
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    check("reset ready", 64'(o_ready), 64'd1);
    check("reset count", 64'(o_log_count), 64'd0);
    check("reset im_rvalid", 64'(o_im_rvalid), 64'd0);
    check("reset dm_rvalid", 64'(o_dm_rvalid), 64'd0);
    check("reset sync_done", 64'(o_sync_done), 64'd0);

    for (int i = 0; i <= 1; i++) apply_vec(i);
    run_sync(1, "syncA");
    im_read(14'd5, 32'hDEADBEEF, "A im5");

    for (int i = 2; i <= 5; i++) apply_vec(i);
    run_sync(2, "syncB");
    im_read(14'd3, 32'h000000A3, "B im3");
    im_read(14'd7, 32'h00000077, "B im7");

    for (int i = 6; i <= 9; i++) apply_vec(i);
    im_read(14'd5, 32'hDEADBEEF, "C im5 old");
    run_sync(2, "syncC");
    im_read(14'd9, 32'h11BB33DD, "C im9");
    im_read(14'd5, 32'h5555AAAA, "C im5 new");

    for (int i = 10; i <= 12; i++) apply_vec(i);
    run_sync(3, "syncD");
    im_read(14'd20, 32'h2020ABCD, "D im20");
    im_read(14'd21, 32'h21212121, "D im21");

    run_sync(0, "empty");
    run_sync(1, "wrfence", 1'b1, 14'd12, 32'hC0FFEE12);
    im_read(14'd12, 32'hC0FFEE12, "wrfence im12");

    // Fill the log completely with distinct addresses; no fence.
    for (int i = 0; i < 256; i++) begin
      i_dm_wen = 1'b1; i_dm_ben = 4'hF;
      i_dm_addr = AW'(100 + i); i_dm_wdata = 32'hF0000000 | 32'(i);
      step();
      idle_inputs();
      if (i == 254) begin
        check("fill 255 count", 64'(o_log_count), 64'd255);
        check("fill 255 ready", 64'(o_ready), 64'd1);
      end
    end
    check("fill full count", 64'(o_log_count), 64'd256);
    check("fill full ready", 64'(o_ready), 64'd0);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 600) begin
      if (o_sync_done) seen = 1'b1;
      else begin
        step();
        waited++;
      end
    end
    check("fill sync_done seen", 64'(seen), 64'd1);
    check("fill sync latency", 64'(waited), 64'd257);
    step();
    check("fill done pulse width", 64'(o_sync_done), 64'd0);
    check("fill end ready", 64'(o_ready), 64'd1);
    check("fill end count", 64'(o_log_count), 64'd0);
    im_read(14'd100, 32'hF0000000, "fill im100");
    im_read(14'd355, 32'hF00000FF, "fill im355");

    // Reset in the middle of a 4-entry drain.
    for (int i = 0; i < 4; i++) begin
      i_dm_wen = 1'b1; i_dm_ben = 4'hF;
      i_dm_addr = AW'(400 + i); i_dm_wdata = 32'(i);
      step();
      idle_inputs();
    end
    i_fence_i = 1'b1;
    step();
    idle_inputs();
    step();
    check("rstmid drain count", 64'(o_log_count), 64'd3);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rstmid count", 64'(o_log_count), 64'd0);
    check("rstmid ready", 64'(o_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rstmid c%0d sync_done", c), 64'(o_sync_done), 64'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
